// File: rtl/booth_pkg.sv
// Shared definitions for the round-robin Booth multiplier scheduler:
// state encoding, default operand width and the watchdog default.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Long enough for a full radix-2 Booth pass plus some controller slack.
  function automatic int timeout_default(input int width);
    return 2 * width + 8;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or after ptr,
// wrapping modulo N_REQ, wins. Grant is one-hot and only driven when en is high.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic         found;
  logic [IDW:0] slot;

  // slot carries one extra bit so ptr+k can exceed N_REQ before wrapping.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    slot      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      slot = {1'b0, ptr} + (IDW + 1)'(k);
      if (slot >= (IDW + 1)'(N_REQ)) begin
        slot = slot - (IDW + 1)'(N_REQ);
      end
      if (!found && req[slot[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = slot[IDW-1:0];
      end
    end
    if (en && found) begin
      grant = N_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one sequential Booth multiplier core between N_REQ requesters,
// with zero-operand bypass and a watchdog that aborts a hung core.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int TIMEOUT = timeout_default(WIDTH),
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_m,
  output logic [WIDTH-1:0]       mul_q,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_product,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [2*WIDTH-1:0]     resp_product,
  output logic                   resp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  sched_state_e       state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mul_start_q, mul_start_d;
  logic [WIDTH-1:0]   mul_m_q, mul_m_d;
  logic [WIDTH-1:0]   mul_q_q, mul_q_d;
  logic               resp_valid_q, resp_valid_d;
  logic [IDW-1:0]     resp_id_q, resp_id_d;
  logic [2*WIDTH-1:0] resp_product_q, resp_product_d;
  logic               resp_err_q, resp_err_d;

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     grant_idx;
  logic               accept;
  logic [WIDTH-1:0]   a_sel, b_sel;

  // Grants are withheld during reset so nothing looks accepted while rst is high.
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        ((state_q == IDLE) && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      cnt_q          <= '0;
      mul_start_q    <= 1'b0;
      mul_m_q        <= '0;
      mul_q_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      cnt_q          <= cnt_d;
      mul_start_q    <= mul_start_d;
      mul_m_q        <= mul_m_d;
      mul_q_q        <= mul_q_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Operands stay in mul_m/mul_q until the next launch so the core sees them stable.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    cnt_d          = cnt_q;
    mul_start_d    = 1'b0;
    mul_m_d        = mul_m_q;
    mul_q_d        = mul_q_q;
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d     = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          resp_id_d = grant_idx;
          if (a_sel == '0 || b_sel == '0) begin
            state_d        = RESP;
            resp_valid_d   = 1'b1;
            resp_product_d = '0;
            resp_err_d     = 1'b0;
          end else begin
            state_d     = LAUNCH;
            mul_start_d = 1'b1;
            mul_m_d     = a_sel;
            mul_q_d     = b_sel;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (mul_done) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_product_d = mul_product;
          resp_err_d     = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_product_d = '0;
          resp_err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_start    = mul_start_q;
  assign mul_m        = mul_m_q;
  assign mul_q        = mul_q_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign resp_err     = resp_err_q;

endmodule
